decodificador_nota_arduino: RTL and testbench

Receiving end of the 3-bit note bus that the game drives toward the Arduino. Synchronizes and debounces the code, decodes it into a note, and generates the buzzer square wave directly on the FPGA, so a board without the Arduino can play the same melody. It also drives one-hot note LEDs and a one-cycle acceptance pulse for the rest of the design.

---
 rtl/sinfonia_pkg.sv | 29 ++
 rtl/decodificador_nota_arduino_if.sv | 30 +++
 rtl/filtro_codigo.sv | 79 +++++++
 rtl/decodificador_nota_arduino.sv | 140 ++++++++++++++
 tb/tb_decodificador_nota_arduino.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sinfonia_pkg.sv
// Shared definitions for the note decoder.
//   - CODE_W     : width of the note code bus
//   - estado_e   : tone FSM states, encoded as seen on db_estado
//   - F_*        : note frequencies in Hz (Dó..Si)
//   - half_periodo: clock cycles per half period of a note
package sinfonia_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    SILENCIO = 2'b00,
    TOCANDO  = 2'b01,
    MUDO     = 2'b10
  } estado_e;

  localparam int F_DO  = 262;
  localparam int F_RE  = 294;
  localparam int F_MI  = 330;
  localparam int F_FA  = 349;
  localparam int F_SOL = 392;
  localparam int F_LA  = 440;
  localparam int F_SI  = 494;

  // Integer division, evaluated at elaboration time.
  function automatic int half_periodo(input int clk_freq, input int freq);
    return clk_freq / (2 * freq);
  endfunction

endpackage

// File: rtl/decodificador_nota_arduino_if.sv
// Note bus between the game logic (master) and the note decoder (slave).
//   codigo      : 3-bit note code, asynchronous to the decoder clock
//   enable      : 1 lets the buzzer sound, 0 mutes it
//   buzzer      : square wave at the accepted note frequency
//   nota_ativa  : accepted code is nonzero
//   nota        : one-hot accepted note, bit k-1 for code k
//   nota_valida : one-cycle pulse when a new code is accepted
//   db_estado   : tone FSM state, for debug
interface decodificador_nota_arduino_if;
  import sinfonia_pkg::*;

  logic [CODE_W-1:0] codigo;
  logic              enable;
  logic              buzzer;
  logic              nota_ativa;
  logic [6:0]        nota;
  logic              nota_valida;
  logic [1:0]        db_estado;

  modport master (
    output codigo, enable,
    input  buzzer, nota_ativa, nota, nota_valida, db_estado
  );

  modport slave (
    input  codigo, enable,
    output buzzer, nota_ativa, nota, nota_valida, db_estado
  );

endinterface

// File: rtl/filtro_codigo.sv
// Two-flop synchronizer plus stability filter for the note code.
//   clk_i, rst_i  : clock and synchronous active-high reset
//   codigo_i      : raw asynchronous note code
//   aceito_o      : last accepted code (registered)
//   nota_valida_o : registered one-cycle pulse, aligned with aceito_o update
//   aceitar_o     : combinational accept strobe for the cycle before the update
//   candidato_o   : code that is being accepted when aceitar_o is high
module filtro_codigo
  import sinfonia_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CODE_W-1:0] codigo_i,
  output logic [CODE_W-1:0] aceito_o,
  output logic              nota_valida_o,
  output logic              aceitar_o,
  output logic [CODE_W-1:0] candidato_o
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0] s1_q, s1_d;
  logic [CODE_W-1:0] s2_q, s2_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] aceito_q, aceito_d;
  logic              valida_q, valida_d;
  logic              aceitar;

  always_comb begin
    s1_d     = codigo_i;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    aceito_d = aceito_q;
    // Acceptance looks at the current candidate/counter, independent of
    // what s2 does in the same cycle.
    aceitar  = (cnt_q == CNT_MAX) && (cand_q != aceito_q);
    valida_d = aceitar;

    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (aceitar) begin
      aceito_d = cand_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      aceito_q <= '0;
      valida_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      aceito_q <= aceito_d;
      valida_q <= valida_d;
    end
  end

  assign aceito_o      = aceito_q;
  assign nota_valida_o = valida_q;
  assign aceitar_o     = aceitar;
  assign candidato_o   = cand_q;

endmodule

// File: rtl/decodificador_nota_arduino.sv
// Receiving end of the 3-bit note bus: filters the code, decodes it into
// one-hot note LEDs and generates the buzzer square wave locally.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : note bus (slave side) carrying codigo/enable in and
//           buzzer/nota_ativa/nota/nota_valida/db_estado out
module decodificador_nota_arduino
  import sinfonia_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic                          clock,
  input  logic                          reset,
  decodificador_nota_arduino_if.slave   bus
);

  localparam int HALF_DO  = half_periodo(CLK_FREQ, F_DO);
  localparam int HALF_RE  = half_periodo(CLK_FREQ, F_RE);
  localparam int HALF_MI  = half_periodo(CLK_FREQ, F_MI);
  localparam int HALF_FA  = half_periodo(CLK_FREQ, F_FA);
  localparam int HALF_SOL = half_periodo(CLK_FREQ, F_SOL);
  localparam int HALF_LA  = half_periodo(CLK_FREQ, F_LA);
  localparam int HALF_SI  = half_periodo(CLK_FREQ, F_SI);

  // Dó is the lowest note, so it has the largest half period; the counter
  // only ever holds values up to HALF-1.
  localparam int TW = (HALF_DO > 1) ? $clog2(HALF_DO) : 1;

  logic [CODE_W-1:0] aceito;
  logic [CODE_W-1:0] candidato;
  logic              aceitar;
  logic              nota_valida;

  filtro_codigo #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filtro (
    .clk_i         (clock),
    .rst_i         (reset),
    .codigo_i      (bus.codigo),
    .aceito_o      (aceito),
    .nota_valida_o (nota_valida),
    .aceitar_o     (aceitar),
    .candidato_o   (candidato)
  );

  // Terminal count (HALF-1) for the currently accepted note.
  logic [TW-1:0] half_m1;
  always_comb begin
    half_m1 = '0;
    case (aceito)
      3'd1:    half_m1 = TW'(HALF_DO  - 1);
      3'd2:    half_m1 = TW'(HALF_RE  - 1);
      3'd3:    half_m1 = TW'(HALF_MI  - 1);
      3'd4:    half_m1 = TW'(HALF_FA  - 1);
      3'd5:    half_m1 = TW'(HALF_SOL - 1);
      3'd6:    half_m1 = TW'(HALF_LA  - 1);
      3'd7:    half_m1 = TW'(HALF_SI  - 1);
      default: half_m1 = '0;
    endcase
  end

  estado_e       estado_q, estado_d;
  logic [TW-1:0] tom_q, tom_d;
  logic          buzzer_q, buzzer_d;

  always_comb begin
    estado_d = estado_q;
    tom_d    = tom_q;
    buzzer_d = buzzer_q;

    if (aceitar) begin
      // Accept decides the target first; a low enable then turns a
      // playing target into MUDO. Any accept restarts the tone phase.
      tom_d    = '0;
      buzzer_d = 1'b0;
      if (candidato == '0) begin
        estado_d = SILENCIO;
      end else if (bus.enable) begin
        estado_d = TOCANDO;
      end else begin
        estado_d = MUDO;
      end
    end else begin
      case (estado_q)
        SILENCIO: begin
          tom_d    = '0;
          buzzer_d = 1'b0;
        end
        TOCANDO: begin
          if (!bus.enable) begin
            estado_d = MUDO;
            tom_d    = '0;
            buzzer_d = 1'b0;
          end else if (tom_q == half_m1) begin
            tom_d    = '0;
            buzzer_d = ~buzzer_q;
          end else begin
            tom_d = tom_q + TW'(1);
          end
        end
        MUDO: begin
          tom_d    = '0;
          buzzer_d = 1'b0;
          if (bus.enable) begin
            estado_d = TOCANDO;
          end
        end
        default: begin
          estado_d = SILENCIO;
          tom_d    = '0;
          buzzer_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= SILENCIO;
      tom_q    <= '0;
      buzzer_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tom_q    <= tom_d;
      buzzer_q <= buzzer_d;
    end
  end

  // One-hot decode: shift a 1 by the code and drop bit 0 (silence).
  logic [7:0] onehot;
  assign onehot = 8'(1) << aceito;

  assign bus.nota        = onehot[7:1];
  assign bus.nota_ativa  = |aceito;
  assign bus.nota_valida = nota_valida;
  assign bus.buzzer      = buzzer_q;
  assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_decodificador_nota_arduino.sv
module tb_decodificador_nota_arduino;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  decodificador_nota_arduino_if bus ();

  decodificador_nota_arduino #(
    .CLK_FREQ      (52400),
    .STABLE_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts edges until buzzer reads 1 (bounded).
  task automatic wait_rise(output int n, input int limit);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.buzzer !== 1'b1 && n < limit);
  endtask

  // Starting on a rise: edges until the next rise (bounded).
  task automatic medir_periodo(output int n, input int limit);
    n = 0;
    while (bus.buzzer === 1'b1 && n < limit) begin tick(); n++; end
    while (bus.buzzer !== 1'b1 && n < limit) begin tick(); n++; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_n(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.codigo = 3'd0;
    bus.enable = 1'b1;
    reset = 1'b1;
    tick_n(2);
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%b exp=0", bus.buzzer); end
    checks++; if (bus.nota_ativa !== 1'b0) begin failures++; $display("FAIL reset_nota_ativa got=%b exp=0", bus.nota_ativa); end
    checks++; if (bus.nota !== 7'd0) begin failures++; $display("FAIL reset_nota got=%b exp=0000000", bus.nota); end
    checks++; if (bus.nota_valida !== 1'b0) begin failures++; $display("FAIL reset_nota_valida got=%b exp=0", bus.nota_valida); end
    checks++; if (bus.db_estado !== 2'b00) begin failures++; $display("FAIL reset_db_estado got=%b exp=00", bus.db_estado); end
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    bit pulso;
    bit buz;
    do_reset();
    bus.codigo = 3'd1;
    tick_n(3);
    bus.codigo = 3'd0;
    pulso = 0;
    buz   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.nota_valida === 1'b1) pulso = 1;
      if (bus.buzzer === 1'b1) buz = 1;
    end
    checks++; if (pulso !== 1'b0) begin failures++; $display("FAIL glitch_pulse got=%b exp=0", pulso); end
    checks++; if (bus.nota !== 7'd0) begin failures++; $display("FAIL glitch_nota got=%b exp=0000000", bus.nota); end
    checks++; if (buz !== 1'b0) begin failures++; $display("FAIL glitch_buzzer got=%b exp=0", buz); end
  endtask

  task automatic test_acceptance();
    int n;
    do_reset();
    bus.codigo = 3'd1;
    bus.enable = 1'b1;
    tick_n(6);
    checks++; if (bus.nota_valida !== 1'b0 || bus.nota !== 7'd0) begin failures++; $display("FAIL accept_early valida=%b nota=%b exp 0/0000000", bus.nota_valida, bus.nota); end
    tick();
    checks++; if (bus.nota_valida !== 1'b1) begin failures++; $display("FAIL accept_pulse got=%b exp=1", bus.nota_valida); end
    checks++; if (bus.nota !== 7'b0000001) begin failures++; $display("FAIL accept_nota got=%b exp=0000001", bus.nota); end
    checks++; if (bus.nota_ativa !== 1'b1) begin failures++; $display("FAIL accept_ativa got=%b exp=1", bus.nota_ativa); end
    checks++; if (bus.db_estado !== 2'b01) begin failures++; $display("FAIL accept_estado got=%b exp=01", bus.db_estado); end
    tick();
    checks++; if (bus.nota_valida !== 1'b0) begin failures++; $display("FAIL accept_pulse_width got=%b exp=0", bus.nota_valida); end
    // One edge already consumed after acceptance: 100 - 1.
    wait_rise(n, 400);
    checks++; if (n !== 99) begin failures++; $display("FAIL do_first_rise got=%0d exp=99", n); end
    medir_periodo(n, 600);
    checks++; if (n !== 200) begin failures++; $display("FAIL do_period got=%0d exp=200", n); end
  endtask

  task automatic test_troca_nota();
    int n;
    bus.codigo = 3'd6;
    tick_n(6);
    checks++; if (bus.buzzer !== 1'b1 || bus.nota_valida !== 1'b0) begin failures++; $display("FAIL troca_before buzzer=%b valida=%b exp 1/0", bus.buzzer, bus.nota_valida); end
    tick();
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL troca_buzzer got=%b exp=0", bus.buzzer); end
    checks++; if (bus.nota_valida !== 1'b1) begin failures++; $display("FAIL troca_pulse got=%b exp=1", bus.nota_valida); end
    checks++; if (bus.nota !== 7'b0100000) begin failures++; $display("FAIL troca_nota got=%b exp=0100000", bus.nota); end
    checks++; if (bus.db_estado !== 2'b01) begin failures++; $display("FAIL troca_estado got=%b exp=01", bus.db_estado); end
    wait_rise(n, 400);
    checks++; if (n !== 59) begin failures++; $display("FAIL la_first_rise got=%0d exp=59", n); end
    medir_periodo(n, 600);
    checks++; if (n !== 118) begin failures++; $display("FAIL la_period got=%0d exp=118", n); end
  endtask

  task automatic test_mudo();
    int n;
    bus.enable = 1'b0;
    tick();
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL mudo_buzzer got=%b exp=0", bus.buzzer); end
    checks++; if (bus.db_estado !== 2'b10) begin failures++; $display("FAIL mudo_estado got=%b exp=10", bus.db_estado); end
    tick_n(3);
    checks++; if (bus.db_estado !== 2'b10 || bus.buzzer !== 1'b0 || bus.nota !== 7'b0100000) begin failures++; $display("FAIL mudo_hold estado=%b buzzer=%b nota=%b exp 10/0/0100000", bus.db_estado, bus.buzzer, bus.nota); end
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.db_estado !== 2'b01 || bus.buzzer !== 1'b0) begin failures++; $display("FAIL unmute estado=%b buzzer=%b exp 01/0", bus.db_estado, bus.buzzer); end
    wait_rise(n, 400);
    checks++; if (n !== 59) begin failures++; $display("FAIL unmute_first_rise got=%0d exp=59", n); end
  endtask

  task automatic test_reset_mid_note();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.buzzer !== 1'b0 || bus.nota !== 7'd0 || bus.nota_ativa !== 1'b0) begin failures++; $display("FAIL midreset_out buzzer=%b nota=%b ativa=%b exp 0/0000000/0", bus.buzzer, bus.nota, bus.nota_ativa); end
    checks++; if (bus.db_estado !== 2'b00 || bus.nota_valida !== 1'b0) begin failures++; $display("FAIL midreset_ctrl estado=%b valida=%b exp 00/0", bus.db_estado, bus.nota_valida); end
    tick_n(6);
    checks++; if (bus.nota_valida !== 1'b0 || bus.nota !== 7'd0) begin failures++; $display("FAIL reaccept_early valida=%b nota=%b exp 0/0000000", bus.nota_valida, bus.nota); end
    tick();
    checks++; if (bus.nota_valida !== 1'b1 || bus.nota !== 7'b0100000 || bus.db_estado !== 2'b01) begin failures++; $display("FAIL reaccept valida=%b nota=%b estado=%b exp 1/0100000/01", bus.nota_valida, bus.nota, bus.db_estado); end
  endtask

  task automatic test_silencio();
    int n;
    wait_rise(n, 400);
    checks++; if (n !== 59) begin failures++; $display("FAIL sil_rise got=%0d exp=59", n); end
    bus.codigo = 3'd0;
    tick_n(6);
    checks++; if (bus.buzzer !== 1'b1 || bus.nota_ativa !== 1'b1) begin failures++; $display("FAIL sil_before buzzer=%b ativa=%b exp 1/1", bus.buzzer, bus.nota_ativa); end
    tick();
    checks++; if (bus.nota_valida !== 1'b1) begin failures++; $display("FAIL sil_pulse got=%b exp=1", bus.nota_valida); end
    checks++; if (bus.nota_ativa !== 1'b0 || bus.nota !== 7'd0) begin failures++; $display("FAIL sil_nota ativa=%b nota=%b exp 0/0000000", bus.nota_ativa, bus.nota); end
    checks++; if (bus.db_estado !== 2'b00 || bus.buzzer !== 1'b0) begin failures++; $display("FAIL sil_estado estado=%b buzzer=%b exp 00/0", bus.db_estado, bus.buzzer); end
    tick();
    checks++; if (bus.nota_valida !== 1'b0) begin failures++; $display("FAIL sil_pulse_width got=%b exp=0", bus.nota_valida); end
  endtask

  task automatic test_accept_mudo();
    bit buz;
    bus.enable = 1'b0;
    bus.codigo = 3'd2;
    tick_n(7);
    checks++; if (bus.nota_valida !== 1'b1 || bus.db_estado !== 2'b10 || bus.nota !== 7'b0000010) begin failures++; $display("FAIL amudo valida=%b estado=%b nota=%b exp 1/10/0000010", bus.nota_valida, bus.db_estado, bus.nota); end
    buz = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.buzzer === 1'b1) buz = 1;
    end
    checks++; if (buz !== 1'b0) begin failures++; $display("FAIL amudo_buzzer got=%b exp=0", buz); end
    bus.codigo = 3'd0;
    tick_n(7);
    checks++; if (bus.db_estado !== 2'b00 || bus.nota !== 7'd0 || bus.nota_valida !== 1'b1) begin failures++; $display("FAIL amudo_sil estado=%b nota=%b valida=%b exp 00/0000000/1", bus.db_estado, bus.nota, bus.nota_valida); end
    bus.enable = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.codigo = 3'd0;
    bus.enable = 1'b1;
    test_reset();
    test_glitch();
    test_acceptance();
    test_troca_nota();
    test_mudo();
    test_reset_mid_note();
    test_silencio();
    test_accept_mudo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
